// File: rtl/sparc_ifu_thrreq4_if.sv
// Requester <-> LRU fetch arbiter bundle: request/speculative vectors out,
// combinational one-hot grant back, registered LRU update feedback out.
interface sparc_ifu_thrreq4_if;
  logic [3:0] req_vec;
  logic [3:0] spec_vec;
  logic       use_spec;
  logic [3:0] grant_vec;
  logic [3:0] recent_vec;
  logic       load_recent;

  // Handshake: a grant is taken only when grant_vec is one-hot and lands on a
  // thread that the requester currently presents as eligible (REQ when
  // use_spec=0, SPEC when use_spec=1); load_recent/recent_vec follow one cycle
  // later as the acknowledgement, and a stray grant bit is simply dropped.
  modport master (
    output req_vec, spec_vec, use_spec, recent_vec, load_recent,
    input  grant_vec
  );

  modport slave (
    input  req_vec, spec_vec, use_spec, recent_vec, load_recent,
    output grant_vec
  );
endinterface

// File: rtl/sparc_ifu_thrreq4.sv
// Four per-thread fetch request FSMs feeding the IFU LRU arbiter.
// Optional watchdog on outstanding fetches: define IFU_THRREQ_TIMEOUT_EN.
module sparc_ifu_thrreq4 #(
  parameter int TO_W     = 8,
  parameter int TO_LIMIT = 200
) (
  input  logic                        clk,
  input  logic                        arst_l,
  input  logic [3:0]                  thr_rdy,
  input  logic [3:0]                  thr_kill,
  input  logic                        cmp_vld,
  input  logic [1:0]                  cmp_tid,
  input  logic                        cmp_early,
  sparc_ifu_thrreq4_if.master         arb,
  output logic                        fetch_vld,
  output logic [1:0]                  fetch_tid,
  output logic [3:0]                  busy,
  output logic [3:0]                  timeout_err,
  output logic [7:0]                  state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    REQ   = 2'b01,
    OUTST = 2'b10,
    SPEC  = 2'b11
  } thr_state_e;

  if (TO_LIMIT >= (2 ** TO_W)) begin : g_bad_limit
    $error("TO_LIMIT must be below 2**TO_W");
  end

  thr_state_e st_q [4];
  thr_state_e st_d [4];
  logic [3:0] launch;
  logic [3:0] to_hit;
  logic       grant_onehot;

  assign grant_onehot = (arb.grant_vec != 4'b0000) &&
                        ((arb.grant_vec & (arb.grant_vec - 4'd1)) == 4'b0000);

  always_comb begin
    for (int t = 0; t < 4; t++) begin
      logic acc;
      logic cmp_hit;
      logic early_hit;
      st_d[t]   = st_q[t];
      launch[t] = 1'b0;
      cmp_hit   = cmp_vld && (cmp_tid == 2'(t));
      early_hit = cmp_early && (cmp_tid == 2'(t));
      acc = grant_onehot && arb.grant_vec[t] &&
            (((st_q[t] == REQ) && !arb.use_spec) ||
             ((st_q[t] == SPEC) && arb.use_spec));
      if (thr_kill[t]) begin
        st_d[t] = IDLE;
      end else if (to_hit[t]) begin
        st_d[t] = IDLE;
      end else begin
        unique case (st_q[t])
          IDLE: if (thr_rdy[t]) st_d[t] = REQ;
          REQ: begin
            if (acc) begin
              st_d[t]   = OUTST;
              launch[t] = 1'b1;
            end
          end
          OUTST: begin
            if (cmp_hit)        st_d[t] = thr_rdy[t] ? REQ : IDLE;
            else if (early_hit) st_d[t] = SPEC;
          end
          SPEC: begin
            // A back-to-back grant swallows a same-cycle completion for t.
            if (acc) begin
              st_d[t]   = OUTST;
              launch[t] = 1'b1;
            end else if (cmp_hit) begin
              st_d[t] = thr_rdy[t] ? REQ : IDLE;
            end
          end
          default: st_d[t] = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      for (int t = 0; t < 4; t++) st_q[t] <= IDLE;
      arb.req_vec     <= 4'b0000;
      arb.spec_vec    <= 4'b0000;
      arb.use_spec    <= 1'b0;
      arb.recent_vec  <= 4'b0000;
      arb.load_recent <= 1'b0;
      fetch_vld       <= 1'b0;
      fetch_tid       <= 2'd0;
      busy            <= 4'b0000;
    end else begin
      logic [3:0] req_n;
      logic [3:0] spec_n;
      for (int t = 0; t < 4; t++) begin
        st_q[t]  <= st_d[t];
        req_n[t]  = (st_d[t] == REQ);
        spec_n[t] = (st_d[t] == SPEC);
        busy[t]  <= (st_d[t] != IDLE);
      end
      arb.req_vec     <= req_n;
      arb.spec_vec    <= spec_n;
      arb.use_spec    <= (req_n == 4'b0000) && (spec_n != 4'b0000);
      arb.recent_vec  <= launch;
      arb.load_recent <= |launch;
      fetch_vld       <= |launch;
      fetch_tid       <= {launch[2] | launch[3], launch[1] | launch[3]};
    end
  end

  always_comb begin
    state_dbg = 8'h00;
    for (int t = 0; t < 4; t++) state_dbg[2*t +: 2] = st_q[t];
  end

`ifdef IFU_THRREQ_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt_q [4];
  logic [3:0]      to_err_q;

  always_comb begin
    for (int t = 0; t < 4; t++) begin
      to_hit[t] = ((st_q[t] == OUTST) || (st_q[t] == SPEC)) &&
                  (to_cnt_q[t] == TO_W'(TO_LIMIT - 1));
    end
  end

  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      for (int t = 0; t < 4; t++) to_cnt_q[t] <= '0;
      to_err_q <= 4'b0000;
    end else begin
      for (int t = 0; t < 4; t++) begin
        if ((st_d[t] == OUTST) && (st_q[t] != OUTST))
          to_cnt_q[t] <= '0;
        else if (((st_q[t] == OUTST) || (st_q[t] == SPEC)) && (to_cnt_q[t] != '1))
          to_cnt_q[t] <= to_cnt_q[t] + 1'b1;
      end
      to_err_q <= to_err_q | (to_hit & ~thr_kill);
    end
  end

  assign timeout_err = to_err_q;
`else
  assign to_hit      = 4'b0000;
  assign timeout_err = 4'b0000;
`endif

endmodule
